// File: rtl/operand_align_buffer.sv
// Operand alignment buffer: early A operands queue in an in-order FIFO and each
// late B beat pops the oldest A, emitting the aligned pair one cycle later.
//
// Ports:
//   clk, rst (async, active-high), flush (sync clear)
//   a_valid/a_data   : early operand push
//   b_valid/b_data   : late operand, pops/pairs with oldest A
//   out_valid/out_a/out_b : registered aligned pair (held when idle)
//   count/full       : A occupancy, registered
//   overflow/underflow : sticky error flags, cleared by rst or flush
module operand_align_buffer #(
    parameter int element_width = 64,
    parameter int depth         = 8,
    parameter int addr_width    = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     a_valid,
    input  logic [element_width-1:0] a_data,
    input  logic                     b_valid,
    input  logic [element_width-1:0] b_data,
    output logic                     out_valid,
    output logic [element_width-1:0] out_a,
    output logic [element_width-1:0] out_b,
    output logic [addr_width:0]      count,
    output logic                     full,
    output logic                     overflow,
    output logic                     underflow
);

    localparam logic [addr_width:0] depth_c = (addr_width + 1)'(depth);

    logic [element_width-1:0] mem_q [depth];

    logic [addr_width-1:0]    wr_ptr_q, wr_ptr_d;
    logic [addr_width-1:0]    rd_ptr_q, rd_ptr_d;
    logic [addr_width:0]      count_q, count_d;
    logic                     full_q, full_d;
    logic                     overflow_q, overflow_d;
    logic                     underflow_q, underflow_d;
    logic                     out_valid_q, out_valid_d;
    logic [element_width-1:0] out_a_q, out_a_d;
    logic [element_width-1:0] out_b_q, out_b_d;

    logic empty;
    logic pop;
    logic bypass;
    logic push;
    logic mem_we;

    always_comb begin
        empty  = (count_q == '0);
        pop    = b_valid && !empty;
        // An A meeting a B at an empty FIFO goes straight to the output.
        bypass = b_valid && empty && a_valid;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push   = a_valid && !bypass && (!full_q || pop);
        mem_we = push && !flush;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        full_d      = full_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        out_valid_d = 1'b0;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            full_d      = 1'b0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            out_a_d     = '0;
            out_b_d     = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + addr_width'(1);
            end
            if (pop) begin
                rd_ptr_d    = rd_ptr_q + addr_width'(1);
                out_valid_d = 1'b1;
                out_a_d     = mem_q[rd_ptr_q];
                out_b_d     = b_data;
            end else if (bypass) begin
                out_valid_d = 1'b1;
                out_a_d     = a_data;
                out_b_d     = b_data;
            end
            count_d = count_q
                    + {{addr_width{1'b0}}, push}
                    - {{addr_width{1'b0}}, pop};
            full_d  = (count_d == depth_c);
            if (a_valid && !push && !bypass) begin
                overflow_d = 1'b1;
            end
            if (b_valid && empty && !a_valid) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= a_data;
        end
    end

    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign count     = count_q;
    assign full      = full_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_operand_align_buffer.sv
// Self-checking bench for operand_align_buffer: vector table plus
// hand-written sequences for reset, fill/overflow, full push+pop and flush.
module tb_operand_align_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        a_valid = 1'b0;
    logic [63:0] a_data = '0;
    logic        b_valid = 1'b0;
    logic [63:0] b_data = '0;
    logic        out_valid;
    logic [63:0] out_a;
    logic [63:0] out_b;
    logic [3:0]  count;
    logic        full;
    logic        overflow;
    logic        underflow;

    int n_chk = 0;
    int n_fail = 0;

    operand_align_buffer #(
        .element_width(64),
        .depth(8),
        .addr_width(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .a_valid(a_valid),
        .a_data(a_data),
        .b_valid(b_valid),
        .b_data(b_data),
        .out_valid(out_valid),
        .out_a(out_a),
        .out_b(out_b),
        .count(count),
        .full(full),
        .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        f;
        logic        av;
        logic [63:0] ad;
        logic        bv;
        logic [63:0] bd;
        logic        e_v;
        logic [63:0] e_a;
        logic [63:0] e_b;
        logic [3:0]  e_cnt;
        logic        e_full;
        logic        e_ov;
        logic        e_un;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic f, input logic av, input logic [63:0] ad,
                        input logic bv, input logic [63:0] bd);
        flush   = f;
        a_valid = av;
        a_data  = ad;
        b_valid = bv;
        b_data  = bd;
        @(posedge clk);
        #1;
        flush   = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic fill(input logic [63:0] base);
        for (int i = 0; i < 8; i++) step(0, 1, base + 64'(i), 0, 0);
    endtask

    logic [63:0] q[$];
    logic [63:0] exp_a;

    initial begin
        vecs[0]  = '{0,1,1, 0,0,  0,0,0,   1,0,0,0};
        vecs[1]  = '{0,1,2, 0,0,  0,0,0,   2,0,0,0};
        vecs[2]  = '{0,1,3, 1,10, 1,1,10,  2,0,0,0};
        vecs[3]  = '{0,0,0, 1,20, 1,2,20,  1,0,0,0};
        vecs[4]  = '{0,0,0, 1,30, 1,3,30,  0,0,0,0};
        vecs[5]  = '{0,0,0, 0,0,  0,3,30,  0,0,0,0};
        vecs[6]  = '{0,1,7, 1,9,  1,7,9,   0,0,0,0};
        vecs[7]  = '{0,0,0, 0,0,  0,7,9,   0,0,0,0};
        vecs[8]  = '{0,0,0, 1,5,  0,7,9,   0,0,0,1};
        vecs[9]  = '{0,1,11,0,0,  0,7,9,   1,0,0,1};
        vecs[10] = '{1,1,12,1,13, 0,0,0,   0,0,0,0};
        vecs[11] = '{0,0,0, 0,0,  0,0,0,   0,0,0,0};

        #1;
        chk("rst_valid", 64'(out_valid), 0);
        chk("rst_out_a", out_a, 0);
        chk("rst_count", 64'(count), 0);
        chk("rst_flags", 64'({full, overflow, underflow}), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].f, vecs[i].av, vecs[i].ad, vecs[i].bv, vecs[i].bd);
            chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'(vecs[i].e_v));
            chk($sformatf("v%0d_out_a", i), out_a, vecs[i].e_a);
            chk($sformatf("v%0d_out_b", i), out_b, vecs[i].e_b);
            chk($sformatf("v%0d_count", i), 64'(count), 64'(vecs[i].e_cnt));
            chk($sformatf("v%0d_full", i), 64'(full), 64'(vecs[i].e_full));
            chk($sformatf("v%0d_ovf", i), 64'(overflow), 64'(vecs[i].e_ov));
            chk($sformatf("v%0d_unf", i), 64'(underflow), 64'(vecs[i].e_un));
        end

        // Reset asserted between edges after three pushes and one pair.
        step(0, 1, 41, 0, 0);
        step(0, 1, 42, 0, 0);
        step(0, 1, 43, 1, 44);
        chk("pre_rst_count", 64'(count), 2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(out_valid), 0);
        chk("arst_out", {out_a[31:0], out_b[31:0]}, 0);
        chk("arst_count", 64'(count), 0);
        chk("arst_flags", 64'({full, overflow, underflow}), 0);
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 1, 55);
        chk("post_rst_valid", 64'(out_valid), 0);
        chk("post_rst_unf", 64'(underflow), 1);
        step(1, 0, 0, 0, 0);

        // Fill and overflow.
        for (int i = 0; i < 9; i++) begin
            step(0, 1, 64'(i), 0, 0);
            if (i == 7) begin
                chk("fill_count", 64'(count), 8);
                chk("fill_full", 64'(full), 1);
                chk("fill_ovf", 64'(overflow), 0);
            end
        end
        chk("ovf_count", 64'(count), 8);
        chk("ovf_flag", 64'(overflow), 1);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 1, 100 + 64'(i));
            chk($sformatf("drain%0d_a", i), out_a, 64'(i));
            chk($sformatf("drain%0d_b", i), out_b, 100 + 64'(i));
            chk($sformatf("drain%0d_v", i), 64'(out_valid), 1);
            chk($sformatf("drain%0d_cnt", i), 64'(count), 64'(7 - i));
        end
        chk("drain_full", 64'(full), 0);
        step(0, 0, 0, 1, 199);
        chk("drain_extra_v", 64'(out_valid), 0);
        chk("drain_extra_unf", 64'(underflow), 1);

        // Full with push and pop together, wrapping the pointers.
        step(1, 0, 0, 0, 0);
        q.delete();
        for (int i = 0; i < 8; i++) q.push_back(200 + 64'(i));
        fill(200);
        chk("fp_pre_full", 64'(full), 1);
        for (int i = 0; i < 21; i++) begin
            step(0, 1, 208 + 64'(i), 1, 300 + 64'(i));
            exp_a = q.pop_front();
            q.push_back(208 + 64'(i));
            chk($sformatf("fp%0d_a", i), out_a, exp_a);
            chk($sformatf("fp%0d_b", i), out_b, 300 + 64'(i));
            chk($sformatf("fp%0d_v", i), 64'(out_valid), 1);
            chk($sformatf("fp%0d_cnt", i), 64'(count), 8);
            chk($sformatf("fp%0d_ovf", i), 64'(overflow), 0);
        end

        // Flush with count=5 and overflow set.
        step(1, 0, 0, 0, 0);
        fill(500);
        step(0, 1, 600, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 700);
        chk("fl_pre_count", 64'(count), 5);
        chk("fl_pre_ovf", 64'(overflow), 1);
        step(1, 0, 0, 0, 0);
        chk("fl_count", 64'(count), 0);
        chk("fl_flags", 64'({full, overflow, underflow}), 0);
        chk("fl_valid", 64'(out_valid), 0);
        step(0, 0, 0, 1, 800);
        chk("fl_unf", 64'(underflow), 1);
        chk("fl_unf_valid", 64'(out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
